// File: rtl/pll_ctrl_pkg.sv
// Shared types and M-counter field layout for the hashing-PLL speed controller.
package pll_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RUN,
      S_QUIESCE,
      S_LOAD,
      S_SHIFT,
      S_UPDATE,
      S_WAIT_DONE,
      S_RESET_PLL,
      S_WAIT_LOCK
   } state_e;

   localparam int M_W     = 18;
   localparam int HI_LSB  = 10;
   localparam int LO_LSB  = 2;
   localparam int BYP_BIT = 1;
   localparam int ODD_BIT = 0;

   // Split a multiplier into the altpll high/low count pair plus bypass and odd-division bits.
   function automatic logic [M_W-1:0] m_field(input logic [7:0] m);
      logic [M_W-1:0] f;
      logic [8:0]     m1;
      m1                = {1'b0, m} + 9'd1;
      f                 = '0;
      f[HI_LSB +: 8]    = m1[8:1];
      f[LO_LSB +: 8]    = {1'b0, m[7:1]};
      f[BYP_BIT]        = (m == 8'd1);
      f[ODD_BIT]        = m[0];
      return f;
   endfunction

endpackage

// File: rtl/pll_scan_shifter.sv
// Serialises a PLL scan-chain image MSB first, with data changing only on scanclk falling edges.
module pll_scan_shifter #(
   parameter int CHAIN_BITS = 144
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [CHAIN_BITS-1:0] image,
   output logic                  scanclk,
   output logic                  scanclkena,
   output logic                  scandata,
   output logic                  done
);

   localparam int CNT_W = $clog2(CHAIN_BITS + 1);

   logic [CHAIN_BITS-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  sclk_q, sclk_d;
   logic                  ena_q, ena_d;
   logic                  data_q, data_d;
   logic                  done_q, done_d;

   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      ena_d  = ena_q;
      data_d = data_q;
      done_d = 1'b0;
      if (load) begin
         sreg_d = image << 1;
         data_d = image[CHAIN_BITS-1];
         ena_d  = 1'b1;
         sclk_d = 1'b0;
         cnt_d  = '0;
      end else if (ena_q) begin
         if (!sclk_q) begin
            sclk_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
         end else begin
            // Falling edge: either stop after the last rising edge or present the next bit.
            sclk_d = 1'b0;
            if (cnt_q == CNT_W'(CHAIN_BITS)) begin
               ena_d  = 1'b0;
               data_d = 1'b0;
               done_d = 1'b1;
            end else begin
               data_d = sreg_q[CHAIN_BITS-1];
               sreg_d = {sreg_q[CHAIN_BITS-2:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q <= '0;
         cnt_q  <= '0;
         sclk_q <= 1'b0;
         ena_q  <= 1'b0;
         data_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
         ena_q  <= ena_d;
         data_q <= data_d;
         done_q <= done_d;
      end
   end

   assign scanclk    = sclk_q;
   assign scanclkena = ena_q;
   assign scandata   = data_q;
   assign done       = done_q;

endmodule

// File: rtl/pll_speed_ctrl.sv
// Runtime multiplier controller: quiesce hashers, rescan PLL M-counter, reset PLL, wait for stable lock.
module pll_speed_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int CHAIN_BITS   = 144,
   parameter int M_OFS        = 18,
   parameter int DEFAULT_MULT = 20,
   parameter int MIN_MULT     = 10,
   parameter int MAX_MULT     = 40,
   parameter int DRAIN_CYCLES = 64,
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_STABLE  = 1024,
   parameter int TIMEOUT      = 65535
) (
   input  logic                  osc_clk,
   input  logic                  rstn,
   input  logic                  req_valid,
   input  logic [7:0]            req_mult,
   output logic                  req_ready,
   input  logic [CHAIN_BITS-1:0] base_image,
   output logic                  pll_scanclk,
   output logic                  pll_scanclkena,
   output logic                  pll_scandata,
   output logic                  pll_configupdate,
   input  logic                  pll_scandone,
   output logic                  pll_areset,
   input  logic                  pll_locked,
   output logic                  hash_en,
   output logic [7:0]            cur_mult,
   output logic                  clamped,
   output logic                  err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int LW = $clog2(LOCK_STABLE + 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
   logic [7:0]      new_mult_q, new_mult_d;
   logic [7:0]      cur_mult_q, cur_mult_d;
   logic            clamped_q, clamped_d;
   logic            err_q, err_d;
   logic            hash_en_q, hash_en_d;
   logic            areset_q, areset_d;
   logic            cfgupd_q, cfgupd_d;
   logic            req_ready_q, req_ready_d;
   logic            lock_s1_q, lock_s2_q;

   logic                  accept;
   logic [7:0]            m_req;
   logic                  clip;
   logic                  shift_load;
   logic                  shift_done;
   logic [CHAIN_BITS-1:0] load_img;

   always_comb begin
      load_img                   = base_image;
      load_img[M_OFS +: M_W]     = m_field(new_mult_q);
   end

   assign shift_load = (state_q == S_LOAD);

   pll_scan_shifter #(.CHAIN_BITS(CHAIN_BITS)) u_shift (
      .clk        (osc_clk),
      .rst_n      (rstn),
      .load       (shift_load),
      .image      (load_img),
      .scanclk    (pll_scanclk),
      .scanclkena (pll_scanclkena),
      .scandata   (pll_scandata),
      .done       (shift_done)
   );

   always_comb begin
      m_req = req_mult;
      clip  = 1'b0;
      if (req_mult < 8'(MIN_MULT)) begin
         m_req = 8'(MIN_MULT);
         clip  = 1'b1;
      end else if (req_mult > 8'(MAX_MULT)) begin
         m_req = 8'(MAX_MULT);
         clip  = 1'b1;
      end
   end

   assign accept = req_valid && req_ready_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lock_cnt_d = lock_cnt_q;
      new_mult_d = new_mult_q;
      cur_mult_d = cur_mult_q;
      clamped_d  = clamped_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE, S_RUN: begin
            if (accept) begin
               clamped_d = clamped_q | clip;
               if (m_req != cur_mult_q) begin
                  new_mult_d = m_req;
                  cnt_d      = '0;
                  state_d    = S_QUIESCE;
               end
            end else if (state_q == S_RUN && !lock_s2_q) begin
               cnt_d      = '0;
               lock_cnt_d = '0;
               state_d    = S_WAIT_LOCK;
            end
         end
         S_QUIESCE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DRAIN_CYCLES - 1)) state_d = S_LOAD;
         end
         S_LOAD:   state_d = S_SHIFT;
         S_SHIFT:  if (shift_done) state_d = S_UPDATE;
         S_UPDATE: begin
            cnt_d   = '0;
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            cnt_d = cnt_q + 1'b1;
            if (pll_scandone) begin
               cur_mult_d = new_mult_q;
               cnt_d      = '0;
               state_d    = S_RESET_PLL;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_RESET_PLL: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(RST_CYCLES - 1)) begin
               cnt_d      = '0;
               lock_cnt_d = '0;
               state_d    = S_WAIT_LOCK;
            end
         end
         S_WAIT_LOCK: begin
            cnt_d      = cnt_q + 1'b1;
            lock_cnt_d = lock_s2_q ? lock_cnt_q + 1'b1 : '0;
            if (lock_s2_q && lock_cnt_q == LW'(LOCK_STABLE - 1)) begin
               state_d = S_RUN;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Outputs are registered off the next state so they never glitch.
      hash_en_d   = (state_d == S_RUN);
      cfgupd_d    = (state_d == S_UPDATE);
      areset_d    = (state_d == S_RESET_PLL);
      req_ready_d = (state_d == S_IDLE) || (state_d == S_RUN);
   end

   always_ff @(posedge osc_clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_WAIT_LOCK;
         cnt_q       <= '0;
         lock_cnt_q  <= '0;
         new_mult_q  <= 8'(DEFAULT_MULT);
         cur_mult_q  <= 8'(DEFAULT_MULT);
         clamped_q   <= 1'b0;
         err_q       <= 1'b0;
         hash_en_q   <= 1'b0;
         areset_q    <= 1'b0;
         cfgupd_q    <= 1'b0;
         req_ready_q <= 1'b0;
         lock_s1_q   <= 1'b0;
         lock_s2_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lock_cnt_q  <= lock_cnt_d;
         new_mult_q  <= new_mult_d;
         cur_mult_q  <= cur_mult_d;
         clamped_q   <= clamped_d;
         err_q       <= err_d;
         hash_en_q   <= hash_en_d;
         areset_q    <= areset_d;
         cfgupd_q    <= cfgupd_d;
         req_ready_q <= req_ready_d;
         lock_s1_q   <= pll_locked;
         lock_s2_q   <= lock_s1_q;
      end
   end

   assign req_ready        = req_ready_q;
   assign pll_configupdate = cfgupd_q;
   assign pll_areset       = areset_q;
   assign hash_en          = hash_en_q;
   assign cur_mult         = cur_mult_q;
   assign clamped          = clamped_q;
   assign err              = err_q;

endmodule

// File: tb/tb_pll_speed_ctrl.sv
// Directed bench for pll_speed_ctrl with a behavioural altpll scan/lock model.
module tb_pll_speed_ctrl;

   localparam int CB = 144;
   localparam int MO = 18;

   logic          osc_clk = 1'b0;
   logic          rstn = 1'b0;
   logic          req_valid = 1'b0;
   logic [7:0]    req_mult = 8'd0;
   logic          req_ready;
   logic [CB-1:0] base_image = {4{36'h93C5AF0E1}};
   logic          pll_scanclk, pll_scanclkena, pll_scandata, pll_configupdate, pll_areset;
   logic          pll_scandone = 1'b0;
   logic          pll_locked;
   logic          hash_en, clamped, err;
   logic [7:0]    cur_mult;

   logic          mlock = 1'b0, force_unlock = 1'b0, no_done = 1'b0;
   logic          prev_sclk = 1'b0, prev_ena = 1'b0;
   logic [CB-1:0] chain = '0, cap_chain = '0, exp_chain;
   int            edges = 0, cap_edges = 0, cfg_pulses = 0, done_dly = 0, lk_cnt = 0;
   int            n_chk = 0, n_fail = 0, c0;

   assign pll_locked = mlock & ~force_unlock;

   always #10 osc_clk = ~osc_clk;

   pll_speed_ctrl dut (
      .osc_clk          (osc_clk),
      .rstn             (rstn),
      .req_valid        (req_valid),
      .req_mult         (req_mult),
      .req_ready        (req_ready),
      .base_image       (base_image),
      .pll_scanclk      (pll_scanclk),
      .pll_scanclkena   (pll_scanclkena),
      .pll_scandata     (pll_scandata),
      .pll_configupdate (pll_configupdate),
      .pll_scandone     (pll_scandone),
      .pll_areset       (pll_areset),
      .pll_locked       (pll_locked),
      .hash_en          (hash_en),
      .cur_mult         (cur_mult),
      .clamped          (clamped),
      .err              (err)
   );

   // PLL model: captures the chain on scanclk rises, answers configupdate, relocks after reset.
   always @(negedge osc_clk) begin
      if (pll_scanclkena && !prev_ena) begin
         edges        = 0;
         pll_scandone = 1'b0;
      end
      if (pll_scanclkena && pll_scanclk && !prev_sclk) begin
         chain = {chain[CB-2:0], pll_scandata};
         edges++;
      end
      if (pll_configupdate) begin
         cfg_pulses++;
         cap_chain = chain;
         cap_edges = edges;
         done_dly  = no_done ? -1 : 10;
      end else if (done_dly > 0) begin
         done_dly--;
         if (done_dly == 0) pll_scandone = 1'b1;
      end
      prev_sclk = pll_scanclk;
      prev_ena  = pll_scanclkena;
      if (pll_areset || !rstn) begin
         lk_cnt = 0;
         mlock  = 1'b0;
      end else if (lk_cnt == 100) begin
         mlock = 1'b1;
      end else begin
         lk_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic req(input logic [7:0] m);
      @(negedge osc_clk);
      req_valid = 1'b1;
      req_mult  = m;
      @(negedge osc_clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_run(input string tag, input int budget);
      for (int i = 0; i < budget && hash_en !== 1'b1; i++) @(negedge osc_clk);
      chk(tag, hash_en, 1);
   endtask

   initial begin
      repeat (5) @(negedge osc_clk);
      chk("rst_hash_en", hash_en, 0);
      chk("rst_cur_mult", cur_mult, 20);
      chk("rst_err", err, 0);
      chk("rst_clamped", clamped, 0);
      chk("rst_areset", pll_areset, 0);
      chk("rst_scanena", pll_scanclkena, 0);
      chk("rst_cfgupd", pll_configupdate, 0);
      chk("rst_ready", req_ready, 0);
      rstn = 1'b1;

      repeat (1115) @(negedge osc_clk);
      chk("startup_early", hash_en, 0);
      repeat (25) @(negedge osc_clk);
      chk("startup_run", hash_en, 1);
      chk("startup_mult", cur_mult, 20);
      chk("startup_ready", req_ready, 1);

      // 25: hi 13, lo 12, bypass 0, odd 1; a request during QUIESCE must be dropped
      c0 = cfg_pulses;
      req(8'd25);
      chk("quiesce_hash", hash_en, 0);
      chk("quiesce_ready", req_ready, 0);
      req(8'd33);
      wait_run("m25_run", 4000);
      chk("m25_cfg_pulses", cfg_pulses - c0, 1);
      chk("m25_edges", cap_edges, 144);
      chk("m25_hi", cap_chain[MO+10 +: 8], 13);
      chk("m25_lo", cap_chain[MO+2 +: 8], 12);
      chk("m25_byp", cap_chain[MO+1], 0);
      chk("m25_odd", cap_chain[MO], 1);
      exp_chain = base_image;
      exp_chain[MO +: 18] = {8'd13, 8'd12, 1'b0, 1'b1};
      chk("m25_chain", cap_chain === exp_chain, 1);
      chk("m25_cur", cur_mult, 25);
      chk("m25_clamped", clamped, 0);

      req(8'd60);
      wait_run("m60_run", 4000);
      chk("m60_clamped", clamped, 1);
      chk("m60_hi", cap_chain[MO+10 +: 8], 20);
      chk("m60_lo", cap_chain[MO+2 +: 8], 20);
      chk("m60_odd", cap_chain[MO], 0);
      chk("m60_cur", cur_mult, 40);

      c0 = cfg_pulses;
      req(8'd40);
      repeat (5) @(negedge osc_clk);
      chk("noop_hash", hash_en, 1);
      chk("noop_cfg", cfg_pulses - c0, 0);
      chk("noop_cur", cur_mult, 40);

      no_done = 1'b1;
      req(8'd35);
      for (int i = 0; i < 70000 && err !== 1'b1; i++) @(negedge osc_clk);
      chk("to_err", err, 1);
      chk("to_hash", hash_en, 0);
      chk("to_idle_ready", req_ready, 1);
      chk("to_cur", cur_mult, 40);
      no_done = 1'b0;
      req(8'd30);
      wait_run("m30_run", 4000);
      chk("m30_cur", cur_mult, 30);
      chk("m30_err_sticky", err, 1);
      chk("m30_hi", cap_chain[MO+10 +: 8], 15);
      chk("m30_lo", cap_chain[MO+2 +: 8], 15);

      force_unlock = 1'b1;
      repeat (3) @(negedge osc_clk);
      chk("unlock_hash", hash_en, 0);
      repeat (2) @(negedge osc_clk);
      force_unlock = 1'b0;
      repeat (1015) @(negedge osc_clk);
      chk("relock_early", hash_en, 0);
      repeat (30) @(negedge osc_clk);
      chk("relock_run", hash_en, 1);
      chk("relock_cur", cur_mult, 30);

      req(8'd22);
      for (int i = 0; i < 2000 && edges != 70; i++) @(negedge osc_clk);
      chk("mid_edges", edges, 70);
      rstn = 1'b0;
      #1;
      chk("mid_scanclk", pll_scanclk, 0);
      chk("mid_scanena", pll_scanclkena, 0);
      chk("mid_scandata", pll_scandata, 0);
      chk("mid_cfgupd", pll_configupdate, 0);
      chk("mid_areset", pll_areset, 0);
      chk("mid_hash", hash_en, 0);
      chk("mid_cur", cur_mult, 20);
      chk("mid_err", err, 0);
      chk("mid_clamped", clamped, 0);
      repeat (3) @(negedge osc_clk);
      rstn = 1'b1;
      wait_run("restart_run", 2000);
      chk("restart_cur", cur_mult, 20);
      chk("restart_edges", edges, 70);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
